cr_commit: RTL and testbench
============================

# cr_commit

Architectural condition-register commit stage with per-field scoreboard. It holds the eight 4-bit CR fields and tracks which fields have an in-flight producer (compare, CR-logical, mtcrf). It stalls issue on RAW/WAW hazards and commits writeback results, including full-CR results from the CR-logic unit, under a field mask. It sits downstream of the CR-logic/compare units and upstream of branch resolution and mfcr.

## Interface
Parameters:
- none; field count fixed at 8, field width fixed at 4 (Pu_types::Condition_register).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- iss_valid  in  1  instruction at issue requests CR access
- iss_rd_mask  in  8  fields the instruction reads (bit i = field i)
- iss_wr_mask  in  8  fields the instruction will write
- iss_stall  out  1  combinational; issue must hold this cycle
- wb_valid  in  1  writeback of a CR result this cycle
- wb_mask  in  8  fields to commit
- wb_cr  in  Condition_register  result word; only fields in wb_mask are used
- flush  in  1  squash all in-flight CR producers
- cr_q  out  Condition_register  committed CR, registered
- cr_fwd  out  Condition_register  committed CR with this cycle's writeback merged (combinational bypass)
- pending  out  8  registered scoreboard, bit i = field i has an outstanding producer
- wb_err  out  1  sticky: writeback targeted a non-pending field
- wb_count  out  32  number of accepted writebacks, wraps at 2^32

## Operation
- Field i is cr[i]; bit [3]=LT, [2]=GT, [1]=EQ, [0]=SO. Field 0 is the most significant architectural field.
- Effective writeback mask: wm = wb_valid ? wb_mask : 8'h00.
- Hazard: hz = (iss_rd_mask | iss_wr_mask) & pending & ~wm.
- iss_stall = flush | (iss_valid & (hz != 0)).
- A field cleared by a same-cycle writeback does not stall; its value is supplied via cr_fwd.
- Issue is accepted when iss_valid & ~iss_stall.
- cr_fwd[i] = wm[i] ? wb_cr[i] : cr_q[i].
- Next state, no flush:
  - cr_q <= cr_fwd.
  - pending <= (pending & ~wm) | (accepted ? iss_wr_mask : 0).
- Next state, flush:
  - cr_q <= cr_fwd; the writeback still commits because it is a completed result.
  - pending <= 0.
  - Issue is not accepted.
- Every cycle with wb_valid and wb_mask != 0:
  - wb_count increments.
  - wb_err is set if (wb_mask & ~pending) != 0.
- wb_valid with wb_mask == 0: no state change, no count.
- The CR-logic unit returns a full CR with one modified bit. The writeback source must drive a single-field wb_mask so that other fields' in-flight producers are not overwritten.
- Multi-field masks (mtcrf, 8'hFF) are legal for both issue and writeback.

## Timing
- Reset: cr_q=0, pending=8'h00, wb_err=0, wb_count=0. iss_stall follows the formula with pending=0.
- Latency:
  - Issue acceptance sets pending bits visible in the next cycle.
  - Writeback data appears on cr_fwd in the same cycle and on cr_q in the next cycle.
  - Earliest dependent issue is the same cycle as the producer's writeback.
- Issue and writeback to the same field in the same cycle: the writeback clears, the issue sets, so the field ends pending.
- Reset asserted mid-operation overrides flush, writeback and issue. All state returns to reset values on the next edge.
- No back-pressure on writeback: wb_* is never stalled.

## Test plan
- Reset then idle -> cr_q=0, pending=0, iss_stall=0, wb_count=0, wb_err=0.
- Issue wr_mask=8'h01. Next cycle issue rd_mask=8'h01 -> stalls. Writeback wb_mask=8'h01, wb_cr[0]=4'b0010 in the same cycle -> stall drops, cr_fwd[0]=4'b0010. Next cycle cr_q[0]=4'b0010, pending=0.
- Field 3 pending; writeback of full CR from CR-logic with wb_mask=8'h08 and wb_cr[5]=4'hF -> only field 3 changes, field 5 unchanged.
- Fields 1 and 2 pending; flush together with wb_mask=8'h02 -> field 1 commits, pending=0 next cycle, issue in the flush cycle not accepted.
- Writeback wb_mask=8'h10 with pending=0 -> wb_err=1, and it stays 1 through later clean writebacks until reset.
- Preload wb_count=32'hFFFF_FFFF via 2^32-1 writebacks (or force), one more writeback -> wb_count wraps to 0. Assert reset in the same cycle as issue and writeback -> all reset values next cycle.

Source files
------------

// File: rtl/cr_commit.sv
// cr_commit
//
// Architectural condition-register commit stage with a per-field scoreboard.
// Holds the eight 4-bit CR fields and tracks which fields have an in-flight
// producer (compare, CR-logical, mtcrf). Issue is stalled on RAW/WAW hazards
// against pending fields. Writeback results, including full-CR words from the
// CR-logic unit, are committed under a field mask.
//
// Field i of a CR word is cr[i], with field 0 occupying the most significant
// nibble. Within a field: [3]=LT, [2]=GT, [1]=EQ, [0]=SO. Mask bit i refers
// to field i.
//
// Handshake: issue has no valid/ready pair of its own. An instruction
// presenting iss_valid is accepted in a cycle exactly when iss_stall is low;
// when iss_stall is high the issue stage must hold the instruction. Writeback
// has no back-pressure: every wb_valid cycle is consumed.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   reset        synchronous, active-low reset
//   iss_valid    instruction at issue requests CR access
//   iss_rd_mask  fields the issuing instruction reads
//   iss_wr_mask  fields the issuing instruction will write
//   iss_stall    combinational, issue must hold this cycle
//   wb_valid     writeback of a CR result this cycle
//   wb_mask      fields to commit
//   wb_cr        result word, only fields in wb_mask are used
//   flush        squash all in-flight CR producers
//   cr_q         committed CR, registered
//   cr_fwd       committed CR with this cycle's writeback merged (bypass)
//   pending      registered scoreboard, bit i = field i outstanding
//   wb_err       sticky, a writeback targeted a non-pending field
//   wb_count     accepted (non-empty) writebacks, wraps at 2^32

module cr_commit (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [7:0]       iss_rd_mask,
    input  logic [7:0]       iss_wr_mask,
    output logic             iss_stall,
    input  logic             wb_valid,
    input  logic [7:0]       wb_mask,
    input  logic [0:7][3:0]  wb_cr,
    input  logic             flush,
    output logic [0:7][3:0]  cr_q,
    output logic [0:7][3:0]  cr_fwd,
    output logic [7:0]       pending,
    output logic             wb_err,
    output logic [31:0]      wb_count
);

    logic [7:0]  wm;
    logic [7:0]  hz;
    logic        iss_accept;
    logic [7:0]  pending_nxt;
    logic [31:0] cnt_q;

    // A field being written back this cycle is no longer a hazard: its new
    // value is already available on cr_fwd.
    assign wm         = wb_valid ? wb_mask : 8'h00;
    assign hz         = (iss_rd_mask | iss_wr_mask) & pending & ~wm;
    assign iss_stall  = flush | (iss_valid & (hz != 8'h00));
    assign iss_accept = iss_valid & ~iss_stall;
    assign wb_count   = cnt_q;

    always_comb begin
        cr_fwd = cr_q;
        for (int i = 0; i < 8; i++) begin
            if (wm[i]) begin
                cr_fwd[i] = wb_cr[i];
            end
        end
    end

    // Writeback clears first, then a same-cycle issue may set the same field
    // again, so that field ends pending.
    always_comb begin
        pending_nxt = pending & ~wm;
        if (iss_accept) begin
            pending_nxt = pending_nxt | iss_wr_mask;
        end
        if (flush) begin
            pending_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cr_q    <= '0;
            pending <= 8'h00;
            wb_err  <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            // Completed results commit even during a flush.
            cr_q    <= cr_fwd;
            pending <= pending_nxt;
            if (wm != 8'h00) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if ((wm & ~pending) != 8'h00) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cr_commit.sv
module tb_cr_commit;

    logic             clk;
    logic             reset;
    logic             iss_valid;
    logic [7:0]       iss_rd_mask;
    logic [7:0]       iss_wr_mask;
    logic             iss_stall;
    logic             wb_valid;
    logic [7:0]       wb_mask;
    logic [0:7][3:0]  wb_cr;
    logic             flush;
    logic [0:7][3:0]  cr_q;
    logic [0:7][3:0]  cr_fwd;
    logic [7:0]       pending;
    logic             wb_err;
    logic [31:0]      wb_count;

    cr_commit dut (
        .clk         (clk),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_rd_mask (iss_rd_mask),
        .iss_wr_mask (iss_wr_mask),
        .iss_stall   (iss_stall),
        .wb_valid    (wb_valid),
        .wb_mask     (wb_mask),
        .wb_cr       (wb_cr),
        .flush       (flush),
        .cr_q        (cr_q),
        .cr_fwd      (cr_fwd),
        .pending     (pending),
        .wb_err      (wb_err),
        .wb_count    (wb_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: architectural state as plain arrays
    logic [3:0]  m_cr   [8];
    bit          m_pend [8];
    bit          m_err;
    logic [31:0] m_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_field_written(input int i);
        return wb_valid && wb_mask[i];
    endfunction

    function automatic bit model_stall();
        bit hazard = 0;
        for (int i = 0; i < 8; i++) begin
            if ((iss_rd_mask[i] || iss_wr_mask[i]) && m_pend[i] && !model_field_written(i))
                hazard = 1;
        end
        return flush || (iss_valid && hazard);
    endfunction

    function automatic logic [31:0] model_cr_word();
        logic [0:7][3:0] w;
        for (int i = 0; i < 8; i++) w[i] = m_cr[i];
        return w;
    endfunction

    function automatic logic [31:0] model_fwd_word();
        logic [0:7][3:0] w;
        for (int i = 0; i < 8; i++) w[i] = model_field_written(i) ? wb_cr[i] : m_cr[i];
        return w;
    endfunction

    function automatic logic [7:0] model_pend_bits();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        return p;
    endfunction

    // driver tasks
    task automatic set_in(input bit v, input logic [7:0] rd, input logic [7:0] wr,
                          input bit wv, input logic [7:0] wmk, input logic [31:0] wcr,
                          input bit fl);
        iss_valid   = v;
        iss_rd_mask = rd;
        iss_wr_mask = wr;
        wb_valid    = wv;
        wb_mask     = wmk;
        wb_cr       = wcr;
        flush       = fl;
    endtask

    task automatic idle_in();
        set_in(0, 8'h00, 8'h00, 0, 8'h00, 32'h0, 0);
    endtask

    task automatic check_comb();
        #1;
        chk("iss_stall", {31'b0, iss_stall}, {31'b0, model_stall()});
        chk("cr_fwd", cr_fwd, model_fwd_word());
    endtask

    task automatic check_regs();
        chk("cr_q", cr_q, model_cr_word());
        chk("pending", {24'b0, pending}, {24'b0, model_pend_bits()});
        chk("wb_err", {31'b0, wb_err}, {31'b0, m_err});
        chk("wb_count", wb_count, m_cnt);
    endtask

    // Advances the model by one edge from the current inputs, clocks the DUT,
    // then compares registered state.
    task automatic tick();
        bit acc;
        bit any_wb;
        acc    = iss_valid && !model_stall();
        any_wb = 0;
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                m_cr[i]   = 4'h0;
                m_pend[i] = 0;
            end
            m_err = 0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (model_field_written(i)) begin
                    any_wb = 1;
                    m_cr[i] = wb_cr[i];
                    if (!m_pend[i]) m_err = 1;
                end
            end
            if (any_wb) m_cnt = m_cnt + 1;
            for (int i = 0; i < 8; i++) begin
                if (flush) m_pend[i] = 0;
                else begin
                    if (model_field_written(i)) m_pend[i] = 0;
                    if (acc && iss_wr_mask[i]) m_pend[i] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    logic [0:7][3:0] w;
    logic [7:0]      rmask;

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_cr[i] = 0;
            m_pend[i] = 0;
        end
        m_err = 0;
        m_cnt = 0;
        reset = 0;
        idle_in();
        @(negedge clk);
        tick();
        tick();
        reset = 1;

        // reset then idle
        check_comb();
        chk("idle_stall", {31'b0, iss_stall}, 32'h0);
        tick();
        chk("idle_pending", {24'b0, pending}, 32'h0);

        // RAW on field 0 resolved by same-cycle writeback
        set_in(1, 8'h00, 8'h01, 0, 8'h00, 32'h0, 0);
        check_comb();
        tick();
        set_in(1, 8'h01, 8'h00, 0, 8'h00, 32'h0, 0);
        check_comb();
        chk("raw_stall", {31'b0, iss_stall}, 32'h1);
        w = '0;
        w[0] = 4'b0010;
        set_in(1, 8'h01, 8'h00, 1, 8'h01, w, 0);
        check_comb();
        chk("raw_bypass_stall", {31'b0, iss_stall}, 32'h0);
        chk("raw_fwd0", {28'b0, cr_fwd[0]}, 32'h2);
        tick();
        chk("raw_cr_q0", {28'b0, cr_q[0]}, 32'h2);
        chk("raw_pending", {24'b0, pending}, 32'h0);

        // full-CR writeback masked to field 3
        set_in(1, 8'h00, 8'h08, 0, 8'h00, 32'h0, 0);
        check_comb();
        tick();
        w = '0;
        w[3] = 4'h5;
        w[5] = 4'hF;
        set_in(0, 8'h00, 8'h00, 1, 8'h08, w, 0);
        check_comb();
        tick();
        chk("crl_f3", {28'b0, cr_q[3]}, 32'h5);
        chk("crl_f5", {28'b0, cr_q[5]}, 32'h0);

        // flush with a same-cycle writeback and a blocked issue
        set_in(1, 8'h00, 8'h06, 0, 8'h00, 32'h0, 0);
        check_comb();
        tick();
        w = '0;
        w[1] = 4'hA;
        w[2] = 4'h7;
        set_in(1, 8'h00, 8'h80, 1, 8'h02, w, 1);
        check_comb();
        chk("flush_stall", {31'b0, iss_stall}, 32'h1);
        tick();
        chk("flush_pending", {24'b0, pending}, 32'h0);
        chk("flush_f1", {28'b0, cr_q[1]}, 32'hA);
        chk("flush_f2", {28'b0, cr_q[2]}, 32'h0);

        // wb_valid with empty mask: no state change
        set_in(0, 8'h00, 8'h00, 1, 8'h00, 32'hFFFF_FFFF, 0);
        check_comb();
        tick();

        // sticky wb_err
        w = '0;
        w[4] = 4'h3;
        set_in(0, 8'h00, 8'h00, 1, 8'h10, w, 0);
        check_comb();
        tick();
        chk("err_set", {31'b0, wb_err}, 32'h1);
        set_in(1, 8'h00, 8'h01, 0, 8'h00, 32'h0, 0);
        check_comb();
        tick();
        set_in(0, 8'h00, 8'h00, 1, 8'h01, 32'h9000_0000, 0);
        check_comb();
        tick();
        chk("err_sticky", {31'b0, wb_err}, 32'h1);

        // wb_count wrap: preload the counter
        idle_in();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("cnt_preload", wb_count, 32'hFFFF_FFFF);
        set_in(0, 8'h00, 8'h00, 1, 8'h40, 32'h0000_0C00, 0);
        check_comb();
        tick();
        chk("cnt_wrap", wb_count, 32'h0);

        // reset overrides issue, writeback and flush in the same cycle
        set_in(1, 8'h00, 8'hFF, 1, 8'hFF, 32'h1234_5678, 1);
        reset = 0;
        check_comb();
        tick();
        reset = 1;
        chk("rst_cr_q", cr_q, 32'h0);
        chk("rst_pending", {24'b0, pending}, 32'h0);
        chk("rst_err", {31'b0, wb_err}, 32'h0);
        chk("rst_cnt", wb_count, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rmask = model_pend_bits();
            set_in($urandom_range(0, 3) != 0,
                   8'($urandom & $urandom),
                   8'($urandom & $urandom & $urandom),
                   $urandom_range(0, 2) != 0,
                   ($urandom_range(0, 5) == 0) ? 8'($urandom) : (rmask & 8'($urandom)),
                   $urandom,
                   $urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 79) != 0);
            check_comb();
            tick();
            reset = 1;
        end

        idle_in();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
